// File: rtl/inst_fetch.sv
`default_nettype none
// ============================================================================
// Module   : inst_fetch
// Purpose  : IF stage. Issues instruction-memory requests, tracks outstanding
//            and discarded fetches, and registers the PC/instruction for IF/ID.
// Revision : 1.0
// ============================================================================
module inst_fetch (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc_i,
    input  logic        ce_i,
    input  logic [5:0]  stall_i,
    input  logic        flush_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ack_i,
    input  logic [31:0] imem_rdata_i,
    output logic [31:0] if_pc_o,
    output logic [31:0] if_inst_o,
    output logic        stallreq_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DROP = 2'd2,
        S_HOLD = 2'd3
    } state_t;

    state_t      r_state;
    logic [31:0] r_addr;
    logic [31:0] r_buf_pc;
    logic [31:0] r_buf_inst;

    logic        w_adv;
    logic        w_issue;
    logic        w_deliver;
    logic [31:0] w_dlv_pc;
    logic [31:0] w_dlv_inst;
    logic        w_unused_stall;

    // Only the PC, IF and ID stall bits concern this stage.
    assign w_unused_stall = ^stall_i[5:3];

    assign w_adv   = ~stall_i[0] & ~stall_i[1];
    assign w_issue = (r_state == S_IDLE) & ce_i & ~flush_i;

    assign imem_req_o  = rst & (w_issue | (r_state == S_WAIT) | (r_state == S_DROP));
    assign imem_addr_o = (r_state == S_IDLE) ? pc_i : r_addr;
    assign stallreq_o  = rst & ((r_state == S_DROP) | (imem_req_o & ~imem_ack_i));

    always_comb begin
        w_deliver  = 1'b0;
        w_dlv_pc   = r_addr;
        w_dlv_inst = imem_rdata_i;
        case (r_state)
            S_IDLE: begin
                w_deliver = w_issue & imem_ack_i & w_adv;
                w_dlv_pc  = pc_i;
            end
            S_WAIT: w_deliver = ~flush_i & imem_ack_i & w_adv;
            S_HOLD: begin
                w_deliver  = ~flush_i & w_adv;
                w_dlv_pc   = r_buf_pc;
                w_dlv_inst = r_buf_inst;
            end
            default: w_deliver = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_addr     <= 32'h0;
            r_buf_pc   <= 32'h0;
            r_buf_inst <= 32'h0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_issue) begin
                        if (imem_ack_i) begin
                            if (!w_adv) begin
                                r_buf_pc   <= pc_i;
                                r_buf_inst <= imem_rdata_i;
                                r_state    <= S_HOLD;
                            end
                        end else begin
                            r_addr  <= pc_i;
                            r_state <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (flush_i) begin
                        r_state <= imem_ack_i ? S_IDLE : S_DROP;
                    end else if (imem_ack_i) begin
                        if (w_adv) begin
                            r_state <= S_IDLE;
                        end else begin
                            r_buf_pc   <= r_addr;
                            r_buf_inst <= imem_rdata_i;
                            r_state    <= S_HOLD;
                        end
                    end
                end
                // The flushed request must still complete before a new one may go out.
                S_DROP: begin
                    if (imem_ack_i) begin
                        r_state <= S_IDLE;
                    end
                end
                S_HOLD: begin
                    if (flush_i || w_adv) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            if_pc_o   <= 32'h0;
            if_inst_o <= 32'h0;
        end else if (flush_i) begin
            if_pc_o   <= 32'h0;
            if_inst_o <= 32'h0;
        end else if (stall_i[1] && stall_i[2]) begin
            if_pc_o   <= if_pc_o;
            if_inst_o <= if_inst_o;
        end else if (stall_i[1]) begin
            if_pc_o   <= 32'h0;
            if_inst_o <= 32'h0;
        end else if (w_deliver) begin
            if_pc_o   <= w_dlv_pc;
            if_inst_o <= w_dlv_inst;
        end else begin
            if_pc_o   <= 32'h0;
            if_inst_o <= 32'h0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_inst_fetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_inst_fetch
// Purpose  : Scoreboard bench for inst_fetch using directed per-cycle vectors.
// Revision : 1.0
// ============================================================================
module tb_inst_fetch;

    logic        clk;
    logic        rst;
    logic [31:0] pc_i;
    logic        ce_i;
    logic [5:0]  stall_i;
    logic        flush_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ack_i;
    logic [31:0] imem_rdata_i;
    logic [31:0] if_pc_o;
    logic [31:0] if_inst_o;
    logic        stallreq_o;

    inst_fetch dut (
        .clk          (clk),
        .rst          (rst),
        .pc_i         (pc_i),
        .ce_i         (ce_i),
        .stall_i      (stall_i),
        .flush_i      (flush_i),
        .imem_req_o   (imem_req_o),
        .imem_addr_o  (imem_addr_o),
        .imem_ack_i   (imem_ack_i),
        .imem_rdata_i (imem_rdata_i),
        .if_pc_o      (if_pc_o),
        .if_inst_o    (if_inst_o),
        .stallreq_o   (stallreq_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          id;
        logic        req;
        logic [31:0] addr;
        logic        sr;
        logic [31:0] pc;
        logic [31:0] inst;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   step_id  = 0;
    bit   mon_busy = 1'b0;

    task automatic chk(input string name, input int id, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (step %0d): got 0x%08h, expected 0x%08h", name, id, act, exp);
        end
    endtask

    // Monitor: request-side outputs sampled mid-cycle, IF/ID register after the edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #3;
            if (q.size() > 0) begin
                mon_busy = 1'b1;
                e = q.pop_front();
                chk("imem_req", e.id, {31'h0, imem_req_o}, {31'h0, e.req});
                chk("stallreq", e.id, {31'h0, stallreq_o}, {31'h0, e.sr});
                if (e.req) chk("imem_addr", e.id, imem_addr_o, e.addr);
                @(posedge clk);
                #1;
                chk("if_pc", e.id, if_pc_o, e.pc);
                chk("if_inst", e.id, if_inst_o, e.inst);
                mon_busy = 1'b0;
            end
        end
    end

    task automatic step(input logic ce, input logic [31:0] pc, input logic [5:0] st,
                        input logic fl, input logic ack, input logic [31:0] rd,
                        input logic x_req, input logic [31:0] x_addr, input logic x_sr,
                        input logic [31:0] x_pc, input logic [31:0] x_inst);
        exp_t e;
        @(negedge clk);
        #1;
        ce_i = ce; pc_i = pc; stall_i = st; flush_i = fl;
        imem_ack_i = ack; imem_rdata_i = rd;
        step_id++;
        e.id = step_id; e.req = x_req; e.addr = x_addr; e.sr = x_sr;
        e.pc = x_pc; e.inst = x_inst;
        q.push_back(e);
    endtask

    task automatic drain();
        int budget = 20;
        while ((q.size() > 0 || mon_busy) && budget > 0) begin
            @(posedge clk);
            budget--;
        end
        if (budget == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: scoreboard not emptied, got %0d pending, expected 0", q.size());
        end
        #2;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b0; ce_i = 1'b1; pc_i = 32'h40; stall_i = 6'h0; flush_i = 1'b0;
        imem_ack_i = 1'b1; imem_rdata_i = 32'h1234_5678;
        #2;
        chk("reset_req", 0, {31'h0, imem_req_o}, 32'h0);
        chk("reset_stallreq", 0, {31'h0, stallreq_o}, 32'h0);
        chk("reset_pc", 0, if_pc_o, 32'h0);
        chk("reset_inst", 0, if_inst_o, 32'h0);
        ce_i = 1'b0; imem_ack_i = 1'b0;
        @(negedge clk);
        #1 rst = 1'b1;

        // Zero-wait back-to-back fetches
        step(1, 32'h0, 6'h00, 0, 1, 32'h1111_1111, 1, 32'h0, 0, 32'h0, 32'h1111_1111);
        step(1, 32'h4, 6'h00, 0, 1, 32'h2222_2222, 1, 32'h4, 0, 32'h4, 32'h2222_2222);
        step(1, 32'h8, 6'h00, 0, 1, 32'h3333_3333, 1, 32'h8, 0, 32'h8, 32'h3333_3333);
        // Two-cycle wait; address must stay latched while pc_i moves
        step(1, 32'h10, 6'h00, 0, 0, 32'h0,        1, 32'h10, 1, 32'h0, 32'h0);
        step(1, 32'h14, 6'h00, 0, 0, 32'h0,        1, 32'h10, 1, 32'h0, 32'h0);
        step(1, 32'h14, 6'h00, 0, 1, 32'h3401_0001, 1, 32'h10, 0, 32'h10, 32'h3401_0001);
        step(1, 32'h14, 6'h00, 0, 1, 32'hAAAA_0014, 1, 32'h14, 0, 32'h14, 32'hAAAA_0014);
        // Stall with hold: buffer, no request in HOLD, stray ack ignored, release
        step(1, 32'h18, 6'h07, 0, 1, 32'hBBBB_0018, 1, 32'h18, 0, 32'h14, 32'hAAAA_0014);
        step(1, 32'h18, 6'h07, 0, 1, 32'hDEAD_0000, 0, 32'h0,  0, 32'h14, 32'hAAAA_0014);
        step(1, 32'h18, 6'h00, 0, 0, 32'h0,        0, 32'h0,  0, 32'h18, 32'hBBBB_0018);
        step(1, 32'h1C, 6'h00, 0, 1, 32'hCCCC_001C, 1, 32'h1C, 0, 32'h1C, 32'hCCCC_001C);
        // Flush while waiting -> DROP, late data discarded, new pc fetched
        step(1, 32'h20,  6'h00, 0, 0, 32'h0,        1, 32'h20, 1, 32'h0, 32'h0);
        step(1, 32'h100, 6'h00, 1, 0, 32'h0,        1, 32'h20, 1, 32'h0, 32'h0);
        step(1, 32'h100, 6'h00, 0, 0, 32'h0,        1, 32'h20, 1, 32'h0, 32'h0);
        step(1, 32'h100, 6'h00, 0, 1, 32'hEEEE_0020, 1, 32'h20, 1, 32'h0, 32'h0);
        step(1, 32'h100, 6'h00, 0, 1, 32'h0100_AAAA, 1, 32'h100, 0, 32'h100, 32'h0100_AAAA);
        // IF stalled, ID free -> bubble, data kept in HOLD until release
        step(1, 32'h104, 6'h03, 0, 1, 32'h0104_BBBB, 1, 32'h104, 0, 32'h0, 32'h0);
        step(1, 32'h104, 6'h03, 0, 0, 32'h0,        0, 32'h0,   0, 32'h0, 32'h0);
        step(1, 32'h108, 6'h00, 0, 0, 32'h0,        0, 32'h0,   0, 32'h104, 32'h0104_BBBB);
        // Flush coinciding with ack in WAIT drops the data immediately
        step(1, 32'h108, 6'h00, 0, 0, 32'h0,        1, 32'h108, 1, 32'h0, 32'h0);
        step(1, 32'h108, 6'h00, 1, 1, 32'h0000_0099, 1, 32'h108, 0, 32'h0, 32'h0);
        step(1, 32'h10C, 6'h00, 0, 1, 32'h0C0C_0C0C, 1, 32'h10C, 0, 32'h10C, 32'h0C0C_0C0C);
        // PC-only stall: no delivery, bubble, then buffered instruction
        step(1, 32'h110, 6'h01, 0, 1, 32'h0110_0110, 1, 32'h110, 0, 32'h0, 32'h0);
        step(1, 32'h114, 6'h00, 0, 0, 32'h0,        0, 32'h0,   0, 32'h110, 32'h0110_0110);
        // Flush in HOLD discards the buffer
        step(1, 32'h114, 6'h07, 0, 1, 32'h0114_0114, 1, 32'h114, 0, 32'h110, 32'h0110_0110);
        step(1, 32'h114, 6'h07, 1, 0, 32'h0,        0, 32'h0,   0, 32'h0, 32'h0);
        step(1, 32'h118, 6'h00, 0, 1, 32'h0118_0118, 1, 32'h118, 0, 32'h118, 32'h0118_0118);
        // Enter WAIT with outputs held non-zero, then reset asynchronously
        step(1, 32'h200, 6'h06, 0, 0, 32'h0,        1, 32'h200, 1, 32'h118, 32'h0118_0118);
        drain();
        @(negedge clk);
        #1 stall_i = 6'h00; imem_ack_i = 1'b0;
        #1;
        chk("wait_stallreq", 99, {31'h0, stallreq_o}, 32'h1);
        #1 rst = 1'b0;
        #1;
        chk("async_req", 100, {31'h0, imem_req_o}, 32'h0);
        chk("async_stallreq", 100, {31'h0, stallreq_o}, 32'h0);
        chk("async_pc", 100, if_pc_o, 32'h0);
        chk("async_inst", 100, if_inst_o, 32'h0);
        ce_i = 1'b0;
        @(negedge clk);
        #1 rst = 1'b1;
        step(1, 32'h300, 6'h00, 0, 1, 32'h0300_0300, 1, 32'h300, 0, 32'h300, 32'h0300_0300);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/inst_fetch.md
INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, asynchronous and active-low (0 = reset).
REQ-003 SHALL have port pc_i, input, 32 bits: fetch address from pc_reg.
REQ-004 SHALL have port ce_i, input, 1 bit: fetch enable from pc_reg.
REQ-005 SHALL have port stall_i, input, 6 bits: pipeline stall vector from ctrl; bit0 = PC, bit1 = IF, bit2 = ID.
REQ-006 SHALL have port flush_i, input, 1 bit: discard all in-flight fetch state (exception flush).
REQ-007 SHALL have port imem_req_o, output, 1 bit: instruction memory request.
REQ-008 SHALL have port imem_addr_o, output, 32 bits: request address.
REQ-009 SHALL have port imem_ack_i, input, 1 bit: memory returns data this cycle; may arrive in the request cycle (zero-wait).
REQ-010 SHALL have port imem_rdata_i, input, 32 bits: instruction data, valid when imem_ack_i = 1.
REQ-011 SHALL have port if_pc_o, output, 32 bits: registered PC presented to the IF/ID stage.
REQ-012 SHALL have port if_inst_o, output, 32 bits: registered instruction presented to the IF/ID stage.
REQ-013 SHALL have port stallreq_o, output, 1 bit: stall request to ctrl.

Function
REQ-014 SHALL use a four-state FSM: IDLE, WAIT (request outstanding, data wanted), DROP (request outstanding, data to be discarded), HOLD (data buffered but not yet delivered).
REQ-015 SHALL define adv = stall_i[0] == 0 and stall_i[1] == 0; an instruction is delivered only when adv = 1.
REQ-016 SHALL drive imem_req_o = (IDLE and ce_i and not flush_i) or WAIT or DROP, combinationally.
REQ-017 SHALL drive imem_addr_o = pc_i in IDLE; in WAIT and DROP, the address latched at issue; it SHALL remain stable until ack.
REQ-018 SHALL drive stallreq_o = (state == DROP) or (imem_req_o and not imem_ack_i).
REQ-019 IDLE transitions: flush_i or not ce_i -> IDLE; on issue, ack and adv -> deliver, IDLE; ack and not adv -> capture in buffer, HOLD; no ack -> latch address, WAIT.
REQ-020 WAIT transitions: flush_i with ack -> IDLE, data dropped; flush_i without ack -> DROP; ack and adv -> deliver, IDLE; ack and not adv -> HOLD; otherwise stay.
REQ-021 DROP transitions: ack -> IDLE, data never delivered; otherwise stay; flush_i has no further effect.
REQ-022 HOLD transitions: flush_i -> IDLE, buffer discarded; adv -> deliver buffer, IDLE; otherwise stay; no memory request is issued in HOLD.
REQ-023 SHALL update the output register at each edge in this priority order:
- flush_i: if_pc_o and if_inst_o set to 0;
- else stall_i[1] = 1 and stall_i[2] = 1: hold;
- else stall_i[1] = 1 and stall_i[2] = 0: bubble (0, 0);
- else deliver when a delivery occurs (REQ-019..022);
- else bubble (0, 0), including stall_i[0] = 1 with stall_i[1] = 0.
REQ-024 SHALL sustain one instruction per cycle with zero-wait memory; each issued address SHALL be delivered at most once.
REQ-025 SHALL ignore imem_ack_i when no request is outstanding.

Reset
REQ-026 SHALL, while rst = 0, immediately force state IDLE; if_pc_o, if_inst_o, the buffer and the latched address to 0; imem_req_o and stallreq_o to 0.
REQ-027 SHALL issue the first request in the first cycle after rst deasserts in which ce_i = 1.

Verification
REQ-028 Zero-wait memory (ack tied 1), ce_i = 1, stall_i = 0, pc 0x0/0x4/0x8 -> if_pc_o = 0x0/0x4/0x8 one edge later, matching rdata; stallreq_o never 1.
REQ-029 pc_i = 0x10, ack two cycles after the request, rdata 0x34010001 -> req held with addr 0x10 and stallreq_o = 1 for two cycles; next edge if_pc_o = 0x10, if_inst_o = 0x34010001.
REQ-030 stall_i = 6'b000111 when ack arrives -> HOLD; outputs hold previous values; no new request; stall_i = 0 -> buffered instruction delivered once, IDLE.
REQ-031 flush_i one cycle before ack in WAIT -> DROP; stallreq_o = 1 through the ack cycle; outputs 0; nothing delivered; next fetch uses the new pc_i.
REQ-032 stall_i = 6'b000011 with a valid fetch -> bubble (if_pc_o = 0, if_inst_o = 0); data held in HOLD until released.
REQ-033 rst driven low mid-WAIT, asynchronous to clk -> all outputs 0 immediately, without a clock edge; after release, fetch restarts at pc_i.
